// File: rtl/i2c_7seg_target.sv
// i2c_7seg_target
// Write-only I2C target feeding the dual 7-segment display driver.
// SCL/SDA are oversampled in the clk domain, START/STOP are decoded from
// the synchronized lines, and a 7-bit address is matched. Every complete
// data byte written to that address is acknowledged and latched as two hex
// nibbles. Read requests, general call and other addresses get no ACK and
// are ignored until the next START or STOP.
module i2c_7seg_target #(
  parameter logic [6:0] I2C_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [3:0] hex0_data_o,
  output logic [3:0] hex1_data_o,
  output logic       byte_strobe_o,
  output logic [2:0] state_dbg_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } state_t;

  // ------------------------------------------------------------------------
  // Input conditioning
  // ------------------------------------------------------------------------
  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  // Two-flop synchronizers plus one history flop per line. They reset to the
  // idle-high bus level so leaving reset never looks like a START.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  logic scl_rise, scl_fall, scl_high;
  logic start_det, stop_det;

  assign scl_rise = scl_sync_q & ~scl_prev_q;
  assign scl_fall = ~scl_sync_q & scl_prev_q;
  // SCL counts as high only once it has been high for two samples, so an
  // SDA edge coincident with the SCL edge is not taken as START/STOP.
  assign scl_high = scl_sync_q & scl_prev_q;

  // SDA may only move while SCL is high to signal START or STOP.
  assign start_det = scl_high & sda_prev_q & ~sda_sync_q;
  assign stop_det  = scl_high & ~sda_prev_q & sda_sync_q;

  // ------------------------------------------------------------------------
  // Protocol FSM
  // ------------------------------------------------------------------------
  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       ack_half_q;   // 0: waiting to drive ACK, 1: ACK being driven
  logic       sda_oe_q;
  logic [3:0] hex0_q;
  logic [3:0] hex1_q;
  logic       strobe_q;

  logic [7:0] shift_d;
  logic       addr_match;

  // Byte as it will look once the bit present on SDA now is shifted in.
  assign shift_d = {shift_q[6:0], sda_sync_q};

  // Only writes (R/W=0) to our own address are accepted; address 0 is the
  // general call and is refused even if I2C_ADDR were set to zero.
  assign addr_match = (shift_d[7:1] == I2C_ADDR) &&
                      (shift_d[7:1] != 7'd0) &&
                      !shift_d[0];

  // Main bus FSM. START/STOP outrank everything else; otherwise the FSM
  // advances on synchronized SCL edges only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      ack_half_q <= 1'b0;
      sda_oe_q   <= 1'b0;
      hex0_q     <= 4'd0;
      hex1_q     <= 4'd0;
      strobe_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (start_det) begin
        // A (repeated) START discards any partial byte and restarts addressing.
        state_q    <= ST_ADDR;
        bit_cnt_q  <= 3'd0;
        shift_q    <= 8'd0;
        ack_half_q <= 1'b0;
        sda_oe_q   <= 1'b0;
      end else if (stop_det) begin
        state_q    <= ST_IDLE;
        bit_cnt_q  <= 3'd0;
        ack_half_q <= 1'b0;
        sda_oe_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            sda_oe_q <= 1'b0;
          end

          ST_ADDR: begin
            if (scl_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= addr_match ? ST_ADDR_ACK : ST_IGNORE;
              end
            end
          end

          ST_ADDR_ACK, ST_DATA_ACK: begin
            // First SCL fall ends bit 8: pull SDA low for the 9th clock.
            // Second SCL fall ends the 9th clock: release and take data.
            if (scl_fall) begin
              if (!ack_half_q) begin
                sda_oe_q   <= 1'b1;
                ack_half_q <= 1'b1;
              end else begin
                sda_oe_q   <= 1'b0;
                ack_half_q <= 1'b0;
                bit_cnt_q  <= 3'd0;
                state_q    <= ST_DATA;
              end
            end
          end

          ST_DATA: begin
            if (scl_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                hex1_q   <= shift_d[7:4];
                hex0_q   <= shift_d[3:0];
                strobe_q <= 1'b1;
                state_q  <= ST_DATA_ACK;
              end
            end
          end

          ST_IGNORE: begin
            sda_oe_q <= 1'b0;
          end

          default: begin
            state_q  <= ST_IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe_o      = sda_oe_q;
  assign hex0_data_o   = hex0_q;
  assign hex1_data_o   = hex1_q;
  assign byte_strobe_o = strobe_q;
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_i2c_7seg_target.sv
// Bench for i2c_7seg_target: a bit-banged I2C controller drives the bus
// (open-drain SDA), a reference model predicts ACKs and latched bytes, and a
// strobe monitor checks each latched byte against the expected queue.
module tb_i2c_7seg_target;

  localparam int Q = 8;                 // clk cycles per quarter SCL period
  localparam logic [6:0] TGT = 7'h42;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Bus: controller side drives scl_drv/sda_drv, target pulls via sda_oe_o
  logic       scl_drv;
  logic       sda_drv;
  logic       sda_oe_o;
  logic [3:0] hex0_data_o;
  logic [3:0] hex1_data_o;
  logic       byte_strobe_o;
  logic [2:0] state_dbg_o;
  logic       sda_line;

  assign sda_line = sda_drv & ~sda_oe_o;

  i2c_7seg_target #(.I2C_ADDR(TGT)) dut (
    .clk          (clk),
    .rst          (rst),
    .scl_i        (scl_drv),
    .sda_i        (sda_line),
    .sda_oe_o     (sda_oe_o),
    .hex0_data_o  (hex0_data_o),
    .hex1_data_o  (hex1_data_o),
    .byte_strobe_o(byte_strobe_o),
    .state_dbg_o  (state_dbg_o)
  );

  // Scoreboard
  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_hex = 8'h00;
  int         strobe_cnt = 0;
  int         strobe_wide = 0;
  int         oe_spurious = 0;
  logic       strobe_prev = 1'b0;
  logic [7:0] mon_e;

  // Reference model: only writes to our own address are acknowledged.
  function automatic logic expect_ack(input logic [6:0] a, input logic rw);
    return (a == TGT) && (a != 7'd0) && (rw == 1'b0);
  endfunction

  // Strobe monitor: each strobe must carry the next expected byte.
  always @(negedge clk) begin
    if (byte_strobe_o === 1'b1) begin
      strobe_cnt++;
      if (strobe_prev === 1'b1) strobe_wide++;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL strobe_unexpected: got strobe with hex %h%h, expected no strobe",
                 hex1_data_o, hex0_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        if ({hex1_data_o, hex0_data_o} !== mon_e) begin
          tests_failed++;
          $display("FAIL strobe_byte: got %h%h, expected %h", hex1_data_o, hex0_data_o, mon_e);
        end
      end
    end
    strobe_prev = byte_strobe_o;
  end

  // Driver tasks
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    hold(Q); sda_drv = 1'b0; hold(Q); scl_drv = 1'b0;
  endtask

  task automatic i2c_rstart();
    hold(Q); sda_drv = 1'b1; hold(Q); scl_drv = 1'b1; hold(Q); sda_drv = 1'b0;
    hold(Q); scl_drv = 1'b0;
  endtask

  task automatic i2c_stop();
    hold(Q); sda_drv = 1'b0; hold(Q); scl_drv = 1'b1; hold(Q); sda_drv = 1'b1;
    hold(2 * Q);
  endtask

  // One data bit; the target must never drive SDA during a data bit.
  task automatic send_bit(input logic b);
    hold(Q); sda_drv = b; hold(Q); scl_drv = 1'b1; hold(Q);
    if (sda_oe_o !== 1'b0) oe_spurious++;
    hold(Q); scl_drv = 1'b0;
  endtask

  // 9th clock: 1 = SDA low over the whole high phase, 0 = high throughout,
  // x = changed while SCL was high.
  task automatic ack_bit(output logic acked);
    logic a, b;
    hold(Q); sda_drv = 1'b1; hold(Q); scl_drv = 1'b1;
    hold(1); a = sda_line;
    hold(2 * Q - 1); b = sda_line;
    hold(Q - 1); scl_drv = 1'b0;
    if (!a && !b)     acked = 1'b1;
    else if (a && b)  acked = 1'b0;
    else              acked = 1'bx;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_bit(acked);
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1;
    hold(2);
    rst = 1'b0;
    hold(2);
    tests_run++;
    if ({sda_oe_o, byte_strobe_o, hex1_data_o, hex0_data_o} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got oe=%b strobe=%b hex=%h%h, expected all 0",
               sda_oe_o, byte_strobe_o, hex1_data_o, hex0_data_o);
    end
    exp_hex = 8'h00;
  endtask

  task automatic test_write_a5();
    logic ack; int s0;
    s0 = strobe_cnt; oe_spurious = 0;
    i2c_start();
    send_byte({TGT, 1'b0}, ack);
    tests_run++;
    if (ack !== 1'b1) begin tests_failed++; $display("FAIL a5_addr_ack: got %b, expected 1", ack); end
    exp_q.push_back(8'hA5); exp_hex = 8'hA5;
    send_byte(8'hA5, ack);
    tests_run++;
    if (ack !== 1'b1) begin tests_failed++; $display("FAIL a5_data_ack: got %b, expected 1", ack); end
    i2c_stop();
    tests_run++;
    if ({hex1_data_o, hex0_data_o} !== exp_hex) begin
      tests_failed++; $display("FAIL a5_hex: got %h%h, expected %h", hex1_data_o, hex0_data_o, exp_hex);
    end
    tests_run++;
    if (strobe_cnt - s0 !== 1 || strobe_wide !== 0) begin
      tests_failed++; $display("FAIL a5_strobe: got %0d strobes (%0d wide), expected 1 (0 wide)",
                               strobe_cnt - s0, strobe_wide);
    end
    tests_run++;
    if (oe_spurious !== 0) begin
      tests_failed++; $display("FAIL a5_oe_in_data: got %0d, expected 0", oe_spurious);
    end
  endtask

  // Transaction the model expects to be refused entirely.
  task automatic test_refused(input logic [6:0] a, input logic rw, input logic [7:0] d);
    logic ack; int s0;
    s0 = strobe_cnt; oe_spurious = 0;
    i2c_start();
    send_byte({a, rw}, ack);
    tests_run++;
    if (ack !== expect_ack(a, rw)) begin
      tests_failed++; $display("FAIL refused_addr_ack %h/%b: got %b, expected %b", a, rw, ack, expect_ack(a, rw));
    end
    send_byte(d, ack);
    tests_run++;
    if (ack !== 1'b0) begin
      tests_failed++; $display("FAIL refused_data_ack %h/%b: got %b, expected 0", a, rw, ack);
    end
    i2c_stop();
    tests_run++;
    if ({hex1_data_o, hex0_data_o} !== exp_hex || strobe_cnt != s0 || oe_spurious != 0) begin
      tests_failed++;
      $display("FAIL refused_state %h/%b: got hex %h%h strobes %0d oe %0d, expected hex %h strobes 0 oe 0",
               a, rw, hex1_data_o, hex0_data_o, strobe_cnt - s0, oe_spurious, exp_hex);
    end
  endtask

  task automatic test_multi();
    logic ack; int s0; int nack_cnt;
    logic [7:0] bytes [3];
    bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'hFF;
    s0 = strobe_cnt; oe_spurious = 0; nack_cnt = 0;
    i2c_start();
    send_byte({TGT, 1'b0}, ack);
    if (ack !== 1'b1) nack_cnt++;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(bytes[i]); exp_hex = bytes[i];
      send_byte(bytes[i], ack);
      if (ack !== 1'b1) nack_cnt++;
    end
    i2c_stop();
    tests_run++;
    if (nack_cnt !== 0) begin tests_failed++; $display("FAIL multi_acks: got %0d missing, expected 0", nack_cnt); end
    tests_run++;
    if ({hex1_data_o, hex0_data_o} !== 8'hFF || strobe_cnt - s0 !== 3) begin
      tests_failed++; $display("FAIL multi_result: got hex %h%h strobes %0d, expected ff strobes 3",
                               hex1_data_o, hex0_data_o, strobe_cnt - s0);
    end
  endtask

  task automatic test_abort_rstart();
    logic ack; int s0;
    s0 = strobe_cnt; oe_spurious = 0;
    i2c_start();
    send_byte({TGT, 1'b0}, ack);
    for (int i = 0; i < 4; i++) send_bit(i[0]);   // partial byte, 4 bits
    i2c_rstart();
    send_byte({TGT, 1'b0}, ack);
    tests_run++;
    if (ack !== 1'b1) begin tests_failed++; $display("FAIL abort_addr_ack: got %b, expected 1", ack); end
    exp_q.push_back(8'h07); exp_hex = 8'h07;
    send_byte(8'h07, ack);
    i2c_stop();
    tests_run++;
    if ({hex1_data_o, hex0_data_o} !== 8'h07 || strobe_cnt - s0 !== 1 || ack !== 1'b1) begin
      tests_failed++; $display("FAIL abort_result: got hex %h%h strobes %0d ack %b, expected 07 strobes 1 ack 1",
                               hex1_data_o, hex0_data_o, strobe_cnt - s0, ack);
    end
  endtask

  task automatic test_reset_in_ack();
    logic [7:0] a;
    a = {TGT, 1'b0};
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(a[i]);
    sda_drv = 1'b1;
    hold(Q);
    tests_run++;
    if (sda_oe_o !== 1'b1) begin tests_failed++; $display("FAIL rst_ack_driving: got %b, expected 1", sda_oe_o); end
    rst = 1'b1;
    hold(1);
    rst = 1'b0;
    exp_hex = 8'h00;
    tests_run++;
    if (sda_oe_o !== 1'b0 || {hex1_data_o, hex0_data_o} !== 8'h00) begin
      tests_failed++; $display("FAIL rst_ack_release: got oe=%b hex=%h%h, expected oe=0 hex=00",
                               sda_oe_o, hex1_data_o, hex0_data_o);
    end
    // Finish the 9th clock and close the bus; the target must stay silent.
    oe_spurious = 0;
    send_bit(1'b1);
    i2c_stop();
    tests_run++;
    if (oe_spurious !== 0 || {hex1_data_o, hex0_data_o} !== 8'h00) begin
      tests_failed++; $display("FAIL rst_ack_after: got oe hits %0d hex %h%h, expected 0 and 00",
                               oe_spurious, hex1_data_o, hex0_data_o);
    end
  endtask

  task automatic test_back_to_back();
    logic ack; int s0; int bad;
    s0 = strobe_cnt; bad = 0;
    i2c_start();
    send_byte({TGT, 1'b0}, ack); if (ack !== 1'b1) bad++;
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, ack); if (ack !== 1'b1) bad++;
    i2c_rstart();
    send_byte({TGT, 1'b0}, ack); if (ack !== 1'b1) bad++;
    exp_q.push_back(8'hC3); exp_hex = 8'hC3;
    send_byte(8'hC3, ack); if (ack !== 1'b1) bad++;
    i2c_stop();
    tests_run++;
    if (bad !== 0 || strobe_cnt - s0 !== 2 || {hex1_data_o, hex0_data_o} !== 8'hC3) begin
      tests_failed++; $display("FAIL b2b: got bad acks %0d strobes %0d hex %h%h, expected 0, 2, c3",
                               bad, strobe_cnt - s0, hex1_data_o, hex0_data_o);
    end
  endtask

  task automatic test_random();
    logic ack; logic exp; logic rw; logic [6:0] a; logic [7:0] d;
    int n; int s0; int exp_strobes;
    for (int t = 0; t < 12; t++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = TGT;
        2:       a = 7'($urandom_range(0, 127));
        default: a = 7'd0;
      endcase
      rw = ($urandom_range(0, 3) == 0);
      n = $urandom_range(1, 3);
      exp = expect_ack(a, rw);
      s0 = strobe_cnt; exp_strobes = 0; oe_spurious = 0;
      i2c_start();
      send_byte({a, rw}, ack);
      tests_run++;
      if (ack !== exp) begin
        tests_failed++; $display("FAIL rand_addr_ack %h/%b: got %b, expected %b", a, rw, ack, exp);
      end
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom_range(0, 255));
        if (exp) begin exp_q.push_back(d); exp_hex = d; exp_strobes++; end
        send_byte(d, ack);
        tests_run++;
        if (ack !== exp) begin
          tests_failed++; $display("FAIL rand_data_ack %h: got %b, expected %b", d, ack, exp);
        end
      end
      i2c_stop();
      tests_run++;
      if ({hex1_data_o, hex0_data_o} !== exp_hex || strobe_cnt - s0 !== exp_strobes || oe_spurious !== 0) begin
        tests_failed++;
        $display("FAIL rand_result: got hex %h%h strobes %0d oe %0d, expected %h strobes %0d oe 0",
                 hex1_data_o, hex0_data_o, strobe_cnt - s0, oe_spurious, exp_hex, exp_strobes);
      end
    end
  endtask

  // Sequence and final report
  initial begin
    rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1;
    test_reset();
    test_write_a5();
    test_refused(7'h43, 1'b0, 8'h3C);
    test_refused(TGT, 1'b1, 8'h99);
    test_refused(7'h00, 1'b0, 8'h55);
    test_multi();
    test_abort_rstart();
    test_reset_in_ack();
    test_back_to_back();
    test_random();
    hold(4);
    tests_run++;
    if (exp_q.size() != 0 || strobe_wide != 0) begin
      tests_failed++; $display("FAIL final_scoreboard: got %0d pending, %0d wide strobes, expected 0 and 0",
                               exp_q.size(), strobe_wide);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
